// File: rtl/pre_decode_stage_pkg.sv
// Shared frontend definitions for the pre-decode stage: geometry constants,
// FSM state codes, the held-packet layout and small decode helpers.
package pre_decode_stage_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam int FSQ_IDX_W   = 4;
    localparam int VADDR_W     = 32;
    localparam int FW_OFF_W    = $clog2(FETCH_WIDTH);
    localparam int FW_CNT_W    = FW_OFF_W + 1;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    // FSM encoding kept as plain constants so older tools and scripts can
    // match the raw state values.
    typedef logic [1:0] PdState;
    localparam PdState PD_IDLE = 2'd0;
    localparam PdState PD_HOLD = 2'd1;
    localparam PdState PD_WAIT = 2'd2;

    // One packet already sliced, packed to slot 0 and truncated at a JAL.
    typedef struct packed {
        logic [FETCH_WIDTH-1:0][31:0] inst;
        logic [FSQ_IDX_W-1:0]         fsqIdx;
        logic [FW_CNT_W-1:0]          cnt;
        logic                         redir;
        logic [VADDR_W-1:0]           target;
    } PdPacket;

    // Sign-extended J-type immediate of a JAL instruction.
    function automatic logic [VADDR_W-1:0] jal_imm(input logic [31:0] inst);
        logic [20:0] imm;
        imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        return {{(VADDR_W-21){imm[20]}}, imm};
    endfunction

    // Write-enable mask with the lowest cnt bits set.
    function automatic logic [FETCH_WIDTH-1:0] thermometer(input logic [FW_CNT_W-1:0] cnt);
        logic [FETCH_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask[i] = (FW_CNT_W'(i) < cnt);
        end
        return mask;
    endfunction

endpackage

// File: rtl/pre_decode_stage_slot_decode.sv
// Per-slot pre-decoder: flags an unpredicted JAL inside the valid window and
// computes its jump target from the slot's own PC.
module pd_slot_decode
    import pre_decode_stage_pkg::*;
(
    input  logic [31:0]        inst_i,
    input  logic [VADDR_W-1:0] pc_i,
    input  logic               in_range_i,
    input  logic               pred_end_i,
    output logic               is_jal_o,
    output logic [VADDR_W-1:0] target_o
);

    // The destination register field does not affect the redirect.
    logic unusedRd;
    assign unusedRd = ^inst_i[11:7];

    // A JAL that the FSQ already predicted as the block's taken exit needs no
    // redirect, so it is not reported here.
    assign is_jal_o = in_range_i && !pred_end_i && (inst_i[6:0] == OPC_JAL);

    // The target wraps naturally at the address width.
    assign target_o = pc_i + jal_imm(inst_i);

endmodule

// File: rtl/pre_decode_stage.sv
// Pre-decode stage between the ICache fetch return and the instruction
// buffer. It slices and packs a fetch block, truncates it at the first
// unpredicted JAL and raises a one-cycle redirect for it. It holds one packet.
module pre_decode_stage
    import pre_decode_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect,
    input  logic                      fetch_valid,
    output logic                      fetch_ready,
    input  logic [VADDR_W-1:0]        fetch_pc,
    input  logic [FSQ_IDX_W-1:0]      fetch_fsq_idx,
    input  logic [FW_OFF_W-1:0]       fetch_start_off,
    input  logic [FW_OFF_W-1:0]       fetch_end_off,
    input  logic                      fetch_taken,
    input  logic [FETCH_WIDTH*32-1:0] fetch_data,
    input  logic                      ibuf_full,
    output logic [FETCH_WIDTH-1:0]    pd_en,
    output logic [FW_CNT_W-1:0]       pd_num,
    output logic [FETCH_WIDTH*32-1:0] pd_inst,
    output logic [FSQ_IDX_W-1:0]      pd_fsq_idx,
    output logic                      pd_redirect,
    output logic [VADDR_W-1:0]        pd_redirect_pc
);

    PdState  state_q, state_d;
    PdPacket pkt_q, pkt_d;
    PdPacket capPkt;

    logic [FETCH_WIDTH-1:0][31:0]        dataSlots;
    logic [FETCH_WIDTH-1:0]              slotJal;
    logic [FETCH_WIDTH-1:0][VADDR_W-1:0] slotTarget;
    logic                                jalFound;
    logic [FW_OFF_W-1:0]                 jalSlot;
    logic                                holding;
    logic                                dequeue;
    logic                                capture;

    assign dataSlots = fetch_data;

    // One decoder per raw slot, each with its own PC and window flags.
    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : gSlot
        logic [VADDR_W-1:0] slotPc;
        logic               inRange;
        logic               predEnd;

        assign slotPc  = fetch_pc + VADDR_W'(4 * k);
        assign inRange = (FW_OFF_W'(k) >= fetch_start_off) && (FW_OFF_W'(k) <= fetch_end_off);
        assign predEnd = fetch_taken && (FW_OFF_W'(k) == fetch_end_off);

        pd_slot_decode uSlotDecode (
            .inst_i     (dataSlots[k]),
            .pc_i       (slotPc),
            .in_range_i (inRange),
            .pred_end_i (predEnd),
            .is_jal_o   (slotJal[k]),
            .target_o   (slotTarget[k])
        );
    end

    // Priority find-first: walking downward leaves the lowest flagged slot.
    always_comb begin
        jalFound = 1'b0;
        jalSlot  = '0;
        for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
            if (slotJal[k]) begin
                jalFound = 1'b1;
                jalSlot  = FW_OFF_W'(k);
            end
        end
    end

    // Build the packet to capture: shift slots down to 0, keep up to and
    // including a found JAL, and zero everything past the kept count.
    always_comb begin
        capPkt        = '0;
        capPkt.fsqIdx = fetch_fsq_idx;
        capPkt.redir  = jalFound;
        capPkt.target = jalFound ? slotTarget[jalSlot] : '0;
        if (jalFound) begin
            capPkt.cnt = FW_CNT_W'(jalSlot) - FW_CNT_W'(fetch_start_off) + FW_CNT_W'(1);
        end else begin
            capPkt.cnt = FW_CNT_W'(fetch_end_off) - FW_CNT_W'(fetch_start_off) + FW_CNT_W'(1);
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (FW_CNT_W'(i) < capPkt.cnt) begin
                capPkt.inst[i] = dataSlots[fetch_start_off + FW_OFF_W'(i)];
            end
        end
    end

    // A held packet leaves when the ibuffer has room and no flush is underway.
    // A flush always reports ready so the discarded fetch does not stall.
    assign holding     = (state_q == PD_HOLD);
    assign dequeue     = holding && !ibuf_full && !redirect;
    assign fetch_ready = redirect || (state_q == PD_IDLE) || (state_q == PD_WAIT) ||
                         (dequeue && !pkt_q.redir);
    assign capture     = fetch_valid && !redirect &&
                         ((state_q == PD_IDLE) || (dequeue && !pkt_q.redir));

    // Next-state: flush wins; a redirecting packet parks the stage in WAIT
    // until the flush arrives; otherwise refill in the same cycle as a dequeue.
    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        if (redirect) begin
            state_d = PD_IDLE;
        end else begin
            case (state_q)
                PD_IDLE: begin
                    if (capture) state_d = PD_HOLD;
                end
                PD_HOLD: begin
                    if (dequeue) begin
                        if (pkt_q.redir)  state_d = PD_WAIT;
                        else if (capture) state_d = PD_HOLD;
                        else              state_d = PD_IDLE;
                    end
                end
                PD_WAIT: state_d = PD_WAIT;
                default: state_d = PD_IDLE;
            endcase
        end
        if (capture) pkt_d = capPkt;
    end

    // State and packet registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PD_IDLE;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
        end
    end

    assign pd_en          = dequeue ? thermometer(pkt_q.cnt) : '0;
    assign pd_num         = dequeue ? pkt_q.cnt : '0;
    assign pd_inst        = holding ? pkt_q.inst : '0;
    assign pd_fsq_idx     = holding ? pkt_q.fsqIdx : '0;
    assign pd_redirect    = dequeue && pkt_q.redir;
    assign pd_redirect_pc = pd_redirect ? pkt_q.target : '0;

endmodule

// File: tb/tb_pre_decode_stage.sv
// Self-checking bench for pre_decode_stage: a packet-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pre_decode_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [31:0]  fetch_pc;
    logic [3:0]   fetch_fsq_idx;
    logic [1:0]   fetch_start_off;
    logic [1:0]   fetch_end_off;
    logic         fetch_taken;
    logic [127:0] fetch_data;
    logic         ibuf_full;
    logic [3:0]   pd_en;
    logic [2:0]   pd_num;
    logic [127:0] pd_inst;
    logic [3:0]   pd_fsq_idx;
    logic         pd_redirect;
    logic [31:0]  pd_redirect_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = empty, 1 = holding a packet, 2 = awaiting flush.
    int          mState = 0;
    logic [31:0] mInst [4];
    int          mFsq;
    int          mCnt;
    bit          mRedir;
    logic [31:0] mTarget;

    pre_decode_stage dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_pc        (fetch_pc),
        .fetch_fsq_idx   (fetch_fsq_idx),
        .fetch_start_off (fetch_start_off),
        .fetch_end_off   (fetch_end_off),
        .fetch_taken     (fetch_taken),
        .fetch_data      (fetch_data),
        .ibuf_full       (ibuf_full),
        .pd_en           (pd_en),
        .pd_num          (pd_num),
        .pd_inst         (pd_inst),
        .pd_fsq_idx      (pd_fsq_idx),
        .pd_redirect     (pd_redirect),
        .pd_redirect_pc  (pd_redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Encode a JAL with rd=x1 from a byte offset.
    function automatic logic [31:0] jalEnc(input int imm);
        logic [20:0] b;
        b = imm[20:0];
        return {b[20], b[10:1], b[11], b[19:12], 5'd1, 7'h6F};
    endfunction

    // Jump target from plain integer arithmetic on the immediate fields.
    function automatic logic [31:0] jalTarget(input logic [31:0] pc, input int slot, input logic [31:0] w);
        int imm;
        imm = (int'(w[30:21]) << 1) + (int'(w[20]) << 11) + (int'(w[19:12]) << 12)
              - (w[31] ? (1 << 20) : 0);
        return pc + 32'(4 * slot) + 32'(imm);
    endfunction

    // Model capture: find the first unpredicted JAL, keep slots up to it.
    task automatic modelCapture();
        int          s;
        int          st;
        int          en;
        logic [31:0] w;
        st = int'(fetch_start_off);
        en = int'(fetch_end_off);
        s  = -1;
        for (int k = st; k <= en; k++) begin
            w = fetch_data[32*k +: 32];
            if (s < 0 && w[6:0] == 7'h6F && !(fetch_taken && k == en)) s = k;
        end
        mRedir  = (s >= 0);
        mCnt    = ((s >= 0) ? s : en) - st + 1;
        mFsq    = int'(fetch_fsq_idx);
        mTarget = '0;
        if (s >= 0) begin
            w       = fetch_data[32*s +: 32];
            mTarget = jalTarget(fetch_pc, s, w);
        end
        for (int i = 0; i < 4; i++) begin
            mInst[i] = (i < mCnt) ? fetch_data[32*(st+i) +: 32] : 32'h0;
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    task automatic modelStep();
        bit           held;
        bit           emit;
        bit           expReady;
        logic [3:0]   expEn;
        logic [127:0] expInst;
        held     = !rst && (mState == 1);
        emit     = held && !ibuf_full && !redirect;
        expReady = rst || redirect || (mState != 1) || (emit && !mRedir);
        expEn    = emit ? 4'((1 << mCnt) - 1) : 4'h0;
        expInst  = '0;
        for (int i = 0; i < 4; i++) begin
            if (held && i < mCnt) expInst[32*i +: 32] = mInst[i];
        end
        checkOutput("cyc_pd_en", 128'(pd_en), 128'(expEn));
        checkOutput("cyc_pd_num", 128'(pd_num), emit ? 128'(mCnt) : 128'h0);
        checkOutput("cyc_fetch_ready", 128'(fetch_ready), 128'(expReady));
        checkOutput("cyc_pd_inst", pd_inst, expInst);
        checkOutput("cyc_pd_fsq_idx", 128'(pd_fsq_idx), held ? 128'(mFsq) : 128'h0);
        checkOutput("cyc_pd_redirect", 128'(pd_redirect), 128'(emit && mRedir));
        checkOutput("cyc_pd_redirect_pc", 128'(pd_redirect_pc), (emit && mRedir) ? 128'(mTarget) : 128'h0);

        if (rst || redirect) begin
            mState = 0;
        end else if (mState == 2) begin
            mState = 2;
        end else if (emit && mRedir) begin
            mState = 2;
        end else if (fetch_valid && expReady) begin
            modelCapture();
            mState = 1;
        end else if (emit) begin
            mState = 0;
        end
    endtask

    always @(negedge clk) modelStep();

    task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [3:0] fsq,
                                 input int s, input int e, input bit tk, input logic [127:0] d);
        fetch_valid     = v;
        fetch_pc        = pc;
        fetch_fsq_idx   = fsq;
        fetch_start_off = 2'(s);
        fetch_end_off   = 2'(e);
        fetch_taken     = tk;
        fetch_data      = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [127:0] DATA_PLAIN = {32'hDDDD_0013, 32'hCCCC_0013, 32'hBBBB_0013, 32'hAAAA_0013};
    localparam logic [127:0] DATA_JAL   = {NOP, 32'h0400_00EF, NOP, NOP};

    initial begin
        logic [127:0] rd;
        rst         = 1'b1;
        redirect    = 1'b0;
        ibuf_full   = 1'b0;
        applyStimulus(0, 32'h0, 4'h0, 0, 0, 0, '0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset_fetch_ready", 128'(fetch_ready), 128'h1);
        checkOutput("reset_pd_en", 128'(pd_en), 128'h0);
        tick();
        rst = 1'b0;
        tick();

        // Slot slicing 1..3, no jumps.
        applyStimulus(1, 32'h0000_0100, 4'd3, 1, 3, 0, DATA_PLAIN);
        tick();
        fetch_valid = 1'b0;
        @(negedge clk);
        checkOutput("slice_pd_en", 128'(pd_en), 128'h7);
        checkOutput("slice_pd_num", 128'(pd_num), 128'h3);
        checkOutput("slice_inst0", 128'(pd_inst[31:0]), 128'hBBBB_0013);
        checkOutput("slice_inst1", 128'(pd_inst[63:32]), 128'hCCCC_0013);
        checkOutput("slice_inst2", 128'(pd_inst[95:64]), 128'hDDDD_0013);
        checkOutput("slice_redirect", 128'(pd_redirect), 128'h0);
        tick();

        // Unpredicted JAL in slot 2.
        applyStimulus(1, 32'h0000_1000, 4'd1, 0, 3, 0, DATA_JAL);
        tick();
        fetch_valid = 1'b0;
        @(negedge clk);
        checkOutput("jal_pd_num", 128'(pd_num), 128'h3);
        checkOutput("jal_pd_en", 128'(pd_en), 128'h7);
        checkOutput("jal_redirect", 128'(pd_redirect), 128'h1);
        checkOutput("jal_redirect_pc", 128'(pd_redirect_pc), 128'h1048);
        tick();
        applyStimulus(1, 32'h0000_1010, 4'd2, 0, 3, 0, DATA_PLAIN);
        @(negedge clk);
        checkOutput("wait_ready", 128'(fetch_ready), 128'h1);
        checkOutput("wait_pd_en", 128'(pd_en), 128'h0);
        tick();
        fetch_valid = 1'b0;
        @(negedge clk);
        checkOutput("wait_pd_en2", 128'(pd_en), 128'h0);
        checkOutput("wait_redirect", 128'(pd_redirect), 128'h0);
        tick();
        redirect = 1'b1;
        tick();
        redirect = 1'b0;

        // Predicted JAL ending the block: no redirect.
        applyStimulus(1, 32'h0000_1000, 4'd4, 0, 2, 1, DATA_JAL);
        tick();
        fetch_valid = 1'b0;
        @(negedge clk);
        checkOutput("pred_pd_num", 128'(pd_num), 128'h3);
        checkOutput("pred_redirect", 128'(pd_redirect), 128'h0);
        checkOutput("pred_ready", 128'(fetch_ready), 128'h1);
        tick();

        // Backpressure for three cycles, then streaming.
        ibuf_full = 1'b1;
        applyStimulus(1, 32'h0000_2000, 4'd5, 0, 3, 0, DATA_PLAIN);
        tick();
        applyStimulus(1, 32'h0000_2010, 4'd6, 2, 3, 0, DATA_PLAIN);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("bp_pd_en", 128'(pd_en), 128'h0);
            checkOutput("bp_ready", 128'(fetch_ready), 128'h0);
            tick();
        end
        ibuf_full = 1'b0;
        @(negedge clk);
        checkOutput("bp_release_num", 128'(pd_num), 128'h4);
        checkOutput("bp_release_fsq", 128'(pd_fsq_idx), 128'h5);
        checkOutput("bp_release_ready", 128'(fetch_ready), 128'h1);
        tick();
        applyStimulus(1, 32'h0000_2020, 4'd7, 3, 3, 0, DATA_PLAIN);
        @(negedge clk);
        checkOutput("stream_b_num", 128'(pd_num), 128'h2);
        checkOutput("stream_b_inst0", 128'(pd_inst[31:0]), 128'hCCCC_0013);
        tick();
        fetch_valid = 1'b0;
        @(negedge clk);
        checkOutput("stream_c_num", 128'(pd_num), 128'h1);
        checkOutput("stream_c_inst0", 128'(pd_inst[31:0]), 128'hDDDD_0013);
        checkOutput("stream_c_fsq", 128'(pd_fsq_idx), 128'h7);
        tick();

        // Redirect colliding with an emit and a new fetch.
        applyStimulus(1, 32'h0000_3000, 4'd8, 0, 1, 0, DATA_PLAIN);
        tick();
        applyStimulus(1, 32'h0000_3100, 4'd9, 0, 3, 0, DATA_PLAIN);
        redirect = 1'b1;
        @(negedge clk);
        checkOutput("coll_pd_en", 128'(pd_en), 128'h0);
        checkOutput("coll_ready", 128'(fetch_ready), 128'h1);
        tick();
        redirect    = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clk);
        checkOutput("coll_after_en", 128'(pd_en), 128'h0);
        checkOutput("coll_after_fsq", 128'(pd_fsq_idx), 128'h0);
        tick();

        // Negative JAL at slot 0 from PC 0 wraps the address.
        rd = {NOP, NOP, NOP, jalEnc(-8)};
        applyStimulus(1, 32'h0, 4'd2, 0, 3, 0, rd);
        tick();
        fetch_valid = 1'b0;
        @(negedge clk);
        checkOutput("wrap_num", 128'(pd_num), 128'h1);
        checkOutput("wrap_pc", 128'(pd_redirect_pc), 128'hFFFF_FFF8);
        tick();
        redirect = 1'b1;
        tick();
        redirect = 1'b0;

        // Asynchronous reset while a packet is held.
        ibuf_full = 1'b1;
        applyStimulus(1, 32'h0000_4000, 4'd10, 0, 3, 0, DATA_PLAIN);
        tick();
        fetch_valid = 1'b0;
        checkOutput("ar_pre_fsq", 128'(pd_fsq_idx), 128'hA);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar_ready", 128'(fetch_ready), 128'h1);
        checkOutput("ar_fsq", 128'(pd_fsq_idx), 128'h0);
        checkOutput("ar_inst", pd_inst, 128'h0);
        tick();
        rst       = 1'b0;
        ibuf_full = 1'b0;
        @(negedge clk);
        checkOutput("ar_no_emit", 128'(pd_en), 128'h0);
        tick();

        // Mixed traffic checked by the model.
        for (int n = 0; n < 80; n++) begin
            int s;
            fetch_valid     = ($urandom_range(0, 3) != 0);
            s               = int'($urandom_range(0, 3));
            fetch_start_off = 2'(s);
            fetch_end_off   = 2'(s + int'($urandom_range(0, 3 - s)));
            fetch_taken     = $urandom_range(0, 1) == 1;
            fetch_pc        = {$urandom_range(0, 32'h0FFF_FFFF), 4'h0};
            fetch_fsq_idx   = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0)
                    fetch_data[32*k +: 32] = jalEnc(int'($urandom_range(0, 2047)) * 2 - 2048);
                else
                    fetch_data[32*k +: 32] = {$urandom_range(0, 32'h01FF_FFFF), 7'h33};
            end
            ibuf_full = ($urandom_range(0, 3) == 0);
            redirect  = ($urandom_range(0, 11) == 0);
            tick();
        end
        fetch_valid = 1'b0;
        redirect    = 1'b0;
        ibuf_full   = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
